// File: rtl/trace_merge_collector_if.sv
// Purpose : capture-side and merged-output signal bundle for trace_merge_collector.
// Latency : n/a (signals only).
// Backpressure: out_ready_i is driven by the consumer; capture side has none.
//
// Ports grouped here:
//   ch_valid_i/ch_addr_i/ch_data_i  per-channel event strobes, packed k*W +: W
//   ch_mask_i                       per-channel capture enable (TRACE_CH_MASK_EN only)
//   out_valid_o/out_ready_i         merged event handshake
//   out_ch_o/out_addr_o/out_data_o/out_ts_o  merged event payload
//   overflow_o/drop_cnt_o           sticky drop flag and saturating drop count
// Optional feature macro: TRACE_CH_MASK_EN.
interface trace_merge_collector_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TS_W   = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]        ch_valid_i;
  logic [NUM_CH*ADDR_W-1:0] ch_addr_i;
  logic [NUM_CH*DATA_W-1:0] ch_data_i;
`ifdef TRACE_CH_MASK_EN
  logic [NUM_CH-1:0]        ch_mask_i;
`endif
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [CH_W-1:0]          out_ch_o;
  logic [ADDR_W-1:0]        out_addr_o;
  logic [DATA_W-1:0]        out_data_o;
  logic [TS_W-1:0]          out_ts_o;
  logic                     overflow_o;
  logic [15:0]              drop_cnt_o;

  // master: event source plus merged-stream consumer
  modport master (
`ifdef TRACE_CH_MASK_EN
    output ch_mask_i,
`endif
    output ch_valid_i, ch_addr_i, ch_data_i, out_ready_i,
    input  out_valid_o, out_ch_o, out_addr_o, out_data_o, out_ts_o,
    input  overflow_o, drop_cnt_o
  );

  // slave: the collector itself
  modport slave (
`ifdef TRACE_CH_MASK_EN
    input  ch_mask_i,
`endif
    input  ch_valid_i, ch_addr_i, ch_data_i, out_ready_i,
    output out_valid_o, out_ch_o, out_addr_o, out_data_o, out_ts_o,
    output overflow_o, drop_cnt_o
  );
endinterface

// File: rtl/trace_merge_collector.sv
// Purpose : per-channel trace capture FIFOs merged into one stream in timestamp order.
// Latency : event captured in cycle t is visible at the output in cycle t+1 at the earliest.
// Backpressure: out_ready_i=0 holds out_* stable; a full channel FIFO drops new events (counted).
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   clear_i  synchronous flush of FIFOs, timestamp, overflow flag and drop count
//   bus      trace_merge_collector_if.slave (capture inputs, merged output, drop status)
// Optional feature macro: TRACE_CH_MASK_EN (adds bus.ch_mask_i per-channel capture enable).
module trace_merge_collector #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  input logic                     clear_i,
  trace_merge_collector_if.slave  bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW   = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
  } ent_t;

  ent_t              r_mem   [NUM_CH][DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]       r_wptr  [NUM_CH];
  logic [AW:0]       r_rptr  [NUM_CH];
  logic [TS_W-1:0]   r_ts;
  logic              r_overflow;
  logic [15:0]       r_drop_cnt;

  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_mask;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_drop;
  ent_t              w_head  [NUM_CH];
  logic              w_sel_vld;
  logic [CH_W-1:0]   w_sel;
  ent_t              w_sel_ent;
  logic [TS_W-1:0]   w_age;
  logic [3:0]        w_drop_n;
  logic [16:0]       w_cnt_sum;

`ifdef TRACE_CH_MASK_EN
  assign w_mask = bus.ch_mask_i;
`else
  assign w_mask = '1;
`endif

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      w_empty[k] = (r_wptr[k] == r_rptr[k]);
      w_full[k]  = (r_wptr[k][AW] != r_rptr[k][AW]) &&
                   (r_wptr[k][AW-1:0] == r_rptr[k][AW-1:0]);
      w_head[k]  = r_mem[k][r_rptr[k][AW-1:0]];
    end
  end

  // Oldest-head selection. Scanning upward and replacing only on a strictly
  // older head makes ties fall to the lowest channel index. "Strictly older"
  // is a nonzero modular distance below half the timestamp range.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel     = '0;
    w_sel_ent = '0;
    w_age     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_age = w_sel_ent.ts - w_head[k].ts;
      if (!w_empty[k] && (!w_sel_vld || (w_age != '0 && !w_age[TS_W-1]))) begin
        w_sel_vld = 1'b1;
        w_sel     = CH_W'(k);
        w_sel_ent = w_head[k];
      end
    end
  end

  // A pop of a full FIFO frees the slot the simultaneous push lands in.
  always_comb begin
    w_pop    = '0;
    w_drop_n = '0;
    if (w_sel_vld && bus.out_ready_i) w_pop[w_sel] = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      w_push[k] = bus.ch_valid_i[k] && w_mask[k] && (!w_full[k] || w_pop[k]);
      w_drop[k] = bus.ch_valid_i[k] && w_mask[k] && w_full[k] && !w_pop[k];
      w_drop_n  = w_drop_n + 4'(w_drop[k]);
    end
    w_cnt_sum = {1'b0, r_drop_cnt} + 17'(w_drop_n);
  end

  // Payload is masked to zero by w_sel_ent's default when nothing is queued.
  assign bus.out_valid_o = w_sel_vld;
  assign bus.out_ch_o    = w_sel;
  assign bus.out_addr_o  = w_sel_ent.addr;
  assign bus.out_data_o  = w_sel_ent.data;
  assign bus.out_ts_o    = w_sel_ent.ts;
  assign bus.overflow_o  = r_overflow;
  assign bus.drop_cnt_o  = r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts       <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_wptr[k] <= '0;
        r_rptr[k] <= '0;
      end
    end else if (clear_i) begin
      r_ts       <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_wptr[k] <= '0;
        r_rptr[k] <= '0;
      end
    end else begin
      r_ts <= r_ts + 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_push[k]) r_wptr[k] <= r_wptr[k] + 1'b1;
        if (w_pop[k])  r_rptr[k] <= r_rptr[k] + 1'b1;
      end
      if (|w_drop) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
      end
    end
  end

  // Storage needs no reset: pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_push[k] && !clear_i) begin
        r_mem[k][r_wptr[k][AW-1:0]] <= '{addr: bus.ch_addr_i[k*ADDR_W +: ADDR_W],
                                         data: bus.ch_data_i[k*DATA_W +: DATA_W],
                                         ts:   r_ts};
      end
    end
  end
endmodule

// File: tb/tb_trace_merge_collector.sv
module tb_trace_merge_collector;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic clr_a;
  logic clr_b;

  trace_merge_collector_if #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .TS_W(16)) bus_a ();
  trace_merge_collector_if #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .TS_W(4))  bus_b ();

  trace_merge_collector #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .DEPTH(8), .TS_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear_i(clr_a), .bus(bus_a));
  trace_merge_collector #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .DEPTH(8), .TS_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear_i(clr_b), .bus(bus_b));

  int checks = 0;
  int failures = 0;

  // Reference model of dut_a: plain per-channel lists, unwrapped capture cycle numbers.
  logic [31:0] m_addr [3][8];
  logic [31:0] m_data [3][8];
  int          m_t    [3][8];
  int          m_cnt  [3];
  int          m_cycle;
  int          m_drops;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    m_cycle = 0;
    m_drops = 0;
  endtask

  // Oldest queued event overall; equal ages resolve to the lowest channel.
  function automatic int m_sel();
    int s = -1;
    for (int k = 0; k < 3; k++)
      if (m_cnt[k] > 0 && (s < 0 || m_t[k][0] < m_t[s][0])) s = k;
    return s;
  endfunction

  task automatic check_a(input string tag);
    int s = m_sel();
    if (s < 0) begin
      chk({tag, ".vld"},  64'(bus_a.out_valid_o), 64'd0);
      chk({tag, ".ch"},   64'(bus_a.out_ch_o),    64'd0);
      chk({tag, ".addr"}, 64'(bus_a.out_addr_o),  64'd0);
      chk({tag, ".data"}, 64'(bus_a.out_data_o),  64'd0);
      chk({tag, ".ts"},   64'(bus_a.out_ts_o),    64'd0);
    end else begin
      chk({tag, ".vld"},  64'(bus_a.out_valid_o), 64'd1);
      chk({tag, ".ch"},   64'(bus_a.out_ch_o),    64'(s));
      chk({tag, ".addr"}, 64'(bus_a.out_addr_o),  64'(m_addr[s][0]));
      chk({tag, ".data"}, 64'(bus_a.out_data_o),  64'(m_data[s][0]));
      chk({tag, ".ts"},   64'(bus_a.out_ts_o),    64'(m_t[s][0] % 65536));
    end
    chk({tag, ".ovf"}, 64'(bus_a.overflow_o), 64'(m_drops > 0));
    chk({tag, ".drp"}, 64'(bus_a.drop_cnt_o), 64'((m_drops > 65535) ? 65535 : m_drops));
  endtask

  // One clock: snapshot inputs, advance the model at the edge, return at the next falling edge.
  task automatic cycle();
    int s;
    logic [2:0]  cv;
    logic [95:0] ca;
    logic [95:0] cd;
    logic        rdy;
    logic        clr;
    s   = m_sel();
    cv  = bus_a.ch_valid_i;
    ca  = bus_a.ch_addr_i;
    cd  = bus_a.ch_data_i;
    rdy = bus_a.out_ready_i;
    clr = clr_a;
    @(posedge clk);
    if (clr) begin
      model_clear();
    end else begin
      if (s >= 0 && rdy) begin
        for (int j = 0; j < m_cnt[s] - 1; j++) begin
          m_addr[s][j] = m_addr[s][j+1];
          m_data[s][j] = m_data[s][j+1];
          m_t[s][j]    = m_t[s][j+1];
        end
        m_cnt[s]--;
      end
      for (int k = 0; k < 3; k++) begin
        if (cv[k]) begin
          if (m_cnt[k] < 8) begin
            m_addr[k][m_cnt[k]] = ca[k*32 +: 32];
            m_data[k][m_cnt[k]] = cd[k*32 +: 32];
            m_t[k][m_cnt[k]]    = m_cycle;
            m_cnt[k]++;
          end else begin
            m_drops++;
          end
        end
      end
      m_cycle++;
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    clr_a = 1'b0;
    clr_b = 1'b0;
    bus_a.ch_valid_i = '0; bus_a.ch_addr_i = '0; bus_a.ch_data_i = '0; bus_a.out_ready_i = 1'b0;
    bus_b.ch_valid_i = '0; bus_b.ch_addr_i = '0; bus_b.ch_data_i = '0; bus_b.out_ready_i = 1'b0;
`ifdef TRACE_CH_MASK_EN
    bus_a.ch_mask_i = '1;
    bus_b.ch_mask_i = '1;
`endif
    model_clear();
    @(negedge clk);

    // Reset state
    check_a("reset");
    chk("reset_b.vld", 64'(bus_b.out_valid_o), 64'd0);
    rst_n = 1'b1;

    // Single event captured at ts=5
    for (int i = 0; i < 5; i++) cycle();
    bus_a.ch_valid_i = 3'b001;
    bus_a.ch_addr_i[31:0] = 32'h100;
    bus_a.ch_data_i[31:0] = 32'hDEAD;
    cycle();
    bus_a.ch_valid_i = '0;
    chk("single.vld",  64'(bus_a.out_valid_o), 64'd1);
    chk("single.ch",   64'(bus_a.out_ch_o),    64'd0);
    chk("single.addr", 64'(bus_a.out_addr_o),  64'h100);
    chk("single.data", 64'(bus_a.out_data_o),  64'hDEAD);
    chk("single.ts",   64'(bus_a.out_ts_o),    64'd5);
    check_a("single");

    // Simultaneous capture on all channels at ts=7, drained in channel order
    bus_a.out_ready_i = 1'b1;
    cycle();
    bus_a.ch_valid_i = 3'b111;
    for (int k = 0; k < 3; k++) begin
      bus_a.ch_addr_i[k*32 +: 32] = 32'h200 + 32'(k);
      bus_a.ch_data_i[k*32 +: 32] = 32'h1000 + 32'(k);
    end
    cycle();
    bus_a.ch_valid_i = '0;
    for (int i = 0; i < 3; i++) begin
      chk("simul.ch", 64'(bus_a.out_ch_o), 64'(i));
      chk("simul.ts", 64'(bus_a.out_ts_o), 64'd7);
      check_a("simul");
      cycle();
    end
    check_a("simul_empty");

    // Overflow: 10 events into channel 1 with no draining
    bus_a.out_ready_i = 1'b0;
    bus_a.ch_valid_i = 3'b010;
    for (int i = 0; i < 10; i++) begin
      bus_a.ch_addr_i[63:32] = 32'h300 + 32'(i);
      bus_a.ch_data_i[63:32] = 32'($urandom);
      cycle();
    end
    bus_a.ch_valid_i = '0;
    chk("ovf.drop", 64'(bus_a.drop_cnt_o), 64'd2);
    chk("ovf.flag", 64'(bus_a.overflow_o), 64'd1);
    chk("ovf.addr", 64'(bus_a.out_addr_o), 64'h300);
    check_a("ovf");
    bus_a.out_ready_i = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus_a.out_valid_o) n++;
      check_a("ovf_drain");
      cycle();
    end
    chk("ovf.queued", 64'(n), 64'd8);
    bus_a.out_ready_i = 1'b0;
    bus_a.ch_valid_i = 3'b010;
    cycle();
    bus_a.ch_valid_i = '0;
    clr_a = 1'b1;
    cycle();
    clr_a = 1'b0;
    chk("clr.vld",  64'(bus_a.out_valid_o), 64'd0);
    chk("clr.drop", 64'(bus_a.drop_cnt_o),  64'd0);
    chk("clr.flag", 64'(bus_a.overflow_o),  64'd0);
    check_a("clr");

    // Full channel 0 with a simultaneous pop and push: nothing dropped
    bus_a.ch_valid_i = 3'b001;
    for (int i = 0; i < 8; i++) begin
      bus_a.ch_data_i[31:0] = 32'h50 + 32'(i);
      cycle();
    end
    bus_a.out_ready_i = 1'b1;
    bus_a.ch_data_i[31:0] = 32'h99;
    cycle();
    bus_a.ch_valid_i = '0;
    bus_a.out_ready_i = 1'b0;
    chk("fullpop.drop", 64'(bus_a.drop_cnt_o), 64'd0);
    chk("fullpop.flag", 64'(bus_a.overflow_o), 64'd0);
    bus_a.out_ready_i = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus_a.out_valid_o) n++;
      check_a("fullpop_drain");
      cycle();
    end
    chk("fullpop.queued", 64'(n), 64'd8);

    // Backpressure: events queued, ready held low for 5 cycles
    bus_a.out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_a.ch_valid_i = 3'($urandom_range(1, 7));
      bus_a.ch_addr_i  = {$urandom, $urandom, $urandom};
      bus_a.ch_data_i  = {$urandom, $urandom, $urandom};
      cycle();
    end
    bus_a.ch_valid_i = '0;
    for (int i = 0; i < 5; i++) begin
      check_a("bp");
      cycle();
    end
    check_a("bp_end");

    // Asynchronous reset pulse mid-stream
    rst_n = 1'b0;
    #1;
    chk("arst.vld_a", 64'(bus_a.out_valid_o), 64'd0);
    chk("arst.addr",  64'(bus_a.out_addr_o),  64'd0);
    model_clear();
    #1;
    rst_n = 1'b1;
    check_a("arst");
    bus_a.out_ready_i = 1'b1;
    cycle();
    check_a("arst_after");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      check_a("rnd");
      for (int k = 0; k < 3; k++) bus_a.ch_valid_i[k] = ($urandom_range(0, 99) < 35);
      bus_a.ch_addr_i   = {$urandom, $urandom, $urandom};
      bus_a.ch_data_i   = {$urandom, $urandom, $urandom};
      bus_a.out_ready_i = ($urandom_range(0, 3) != 0);
      clr_a             = ($urandom_range(0, 99) == 0);
      cycle();
    end
    clr_a = 1'b0;
    bus_a.ch_valid_i = '0;
    check_a("rnd_end");

    // Drop counter saturation with all three channels dropping every cycle
    bus_a.out_ready_i = 1'b0;
    clr_a = 1'b1;
    cycle();
    clr_a = 1'b0;
    bus_a.ch_valid_i = 3'b111;
    for (int i = 0; i < 21900; i++) cycle();
    bus_a.ch_valid_i = '0;
    chk("sat.drop", 64'(bus_a.drop_cnt_o), 64'hFFFF);
    check_a("sat");

    // Timestamp wrap on the 4-bit instance
    clr_b = 1'b1;
    cycle();
    clr_b = 1'b0;
    for (int i = 0; i < 14; i++) cycle();
    bus_b.ch_valid_i = 3'b100;
    bus_b.ch_addr_i[95:64] = 32'hA;
    bus_b.ch_data_i[95:64] = 32'hAA;
    cycle();
    bus_b.ch_valid_i = '0;
    cycle();
    cycle();
    bus_b.ch_valid_i = 3'b001;
    bus_b.ch_addr_i[31:0] = 32'hB;
    bus_b.ch_data_i[31:0] = 32'hBB;
    cycle();
    bus_b.ch_valid_i = '0;
    chk("wrap.first_ch",   64'(bus_b.out_ch_o),   64'd2);
    chk("wrap.first_ts",   64'(bus_b.out_ts_o),   64'd14);
    chk("wrap.first_addr", 64'(bus_b.out_addr_o), 64'hA);
    bus_b.out_ready_i = 1'b1;
    cycle();
    chk("wrap.second_ch",   64'(bus_b.out_ch_o),   64'd0);
    chk("wrap.second_ts",   64'(bus_b.out_ts_o),   64'd1);
    chk("wrap.second_data", 64'(bus_b.out_data_o), 64'hBB);
    cycle();
    chk("wrap.empty", 64'(bus_b.out_valid_o), 64'd0);
    bus_b.out_ready_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
